// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: offset removal, 16-bit saturation and
// block averaging of 2^dec_log2 valid samples per output strobe.
module adc_sample_conditioner #(
  parameter int DEC_LOG2_MAX = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adc_in,
  input  logic        adc_valid,
  input  logic [15:0] offset,
  input  logic [2:0]  dec_log2,
  input  logic        enable,
  input  logic        clear_overflow,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        overflow
);

  localparam int ACC_W = 16 + DEC_LOG2_MAX;
  localparam int CNT_W = DEC_LOG2_MAX + 1;
  localparam logic [2:0] DEC_MAX = 3'(DEC_LOG2_MAX);

  localparam logic [0:0] ST_DISABLED = 1'b0;
  localparam logic [0:0] ST_ACCUM    = 1'b1;

  logic [0:0]              state_q, state_d;
  logic                    s1_vld_q, s1_vld_d;
  logic [16:0]             s1_diff_q, s1_diff_d;
  logic                    s2_vld_q, s2_vld_d;
  logic [15:0]             s2_data_q, s2_data_d;
  logic                    s2_sat_q, s2_sat_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              dec_q, dec_d;
  logic [15:0]             out_q, out_d;
  logic                    ovld_q, ovld_d;
  logic                    ovf_q, ovf_d;

  logic [2:0]              dec_clamp;
  logic [2:0]              dec_eff;
  logic [CNT_W-1:0]        blk_last;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic                    run;

  assign dec_clamp = (dec_log2 > DEC_MAX) ? DEC_MAX : dec_log2;
  assign dec_eff   = (cnt_q == '0) ? dec_clamp : dec_q;
  assign blk_last  = ~({CNT_W{1'b1}} << dec_eff);
  assign sum       = acc_q
                   + {{(ACC_W-16){s2_data_q[15]}}, s2_data_q};
  assign shifted   = sum >>> dec_eff;
  assign run       = enable && (state_q == ST_ACCUM) && s2_vld_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DISABLED: if (enable)  state_d = ST_ACCUM;
      ST_ACCUM:    if (!enable) state_d = ST_DISABLED;
      default:     state_d = ST_DISABLED;
    endcase
  end

  always_comb begin
    s1_vld_d  = adc_valid && enable;
    s1_diff_d = {adc_in[15], adc_in} - {offset[15], offset};
    s2_vld_d  = s1_vld_q && enable;
    s2_sat_d  = s1_diff_q[16] != s1_diff_q[15];
    s2_data_d = s1_diff_q[15:0];
    if (s2_sat_d)
      s2_data_d = s1_diff_q[16] ? 16'h8000 : 16'h7fff;
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dec_d  = dec_q;
    out_d  = out_q;
    ovld_d = 1'b0;
    ovf_d  = ovf_q;
    if (clear_overflow) ovf_d = 1'b0;
    if (run && s2_sat_q) ovf_d = 1'b1;
    if (!enable) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == '0) dec_d = dec_clamp;
      if (cnt_q == blk_last) begin
        out_d  = shifted[15:0];
        ovld_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DISABLED;
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_sat_q  <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dec_q     <= '0;
      out_q     <= '0;
      ovld_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_vld_q  <= s1_vld_d;
      s1_diff_q <= s1_diff_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_sat_q  <= s2_sat_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      dec_q     <= dec_d;
      out_q     <= out_d;
      ovld_q    <= ovld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = ovld_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_adc_sample_conditioner.sv
// Bench for adc_sample_conditioner: directed scenarios plus random
// streams checked against a block-average reference model.
module tb_adc_sample_conditioner;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] adc_in;
  logic               adc_valid;
  logic signed [15:0] offset;
  logic [2:0]         dec_log2;
  logic               enable;
  logic               clear_overflow;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               overflow;

  adc_sample_conditioner #(.DEC_LOG2_MAX(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .adc_in         (adc_in),
    .adc_valid      (adc_valid),
    .offset         (offset),
    .dec_log2       (dec_log2),
    .enable         (enable),
    .clear_overflow (clear_overflow),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int obs_q[$];
  int obs_cyc[$];
  int exp_q[$];
  int m_sum, m_cnt, m_len;
  bit m_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (sample_valid) begin
      obs_q.push_back(int'(sample_out));
      obs_cyc.push_back(cyc);
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic model_flush();
    m_sum = 0;
    m_cnt = 0;
  endtask

  task automatic model_push(input int s);
    int q;
    if (m_cnt == 0) m_len = 1 << ((dec_log2 > 6) ? 6 : int'(dec_log2));
    m_sum += s;
    m_cnt++;
    if (m_cnt == m_len) begin
      q = m_sum / m_len;
      if ((m_sum % m_len != 0) && m_sum < 0) q--;
      exp_q.push_back(q);
      model_flush();
    end
  endtask

  task automatic send(input int a, input int o, input int gap);
    int d, s;
    d = a - o;
    s = (d > 32767) ? 32767 : (d < -32768) ? -32768 : d;
    if (enable) begin
      if (s != d) m_ovf = 1;
      model_push(s);
    end
    adc_in    = 16'(a);
    offset    = 16'(o);
    adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    m_ovf = 0;
  endtask

  task automatic clear_q();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; adc_in = '0; adc_valid = 1'b0; offset = '0;
    dec_log2 = '0; enable = 1'b0; clear_overflow = 1'b0;
    model_flush(); m_ovf = 0;
    idle(3);
    rst = 1'b0;
    idle(2);
    n_checks++;
    if ({sample_out, sample_valid, overflow} !== 18'd0)
      $display("FAIL reset_outputs got out=%0d v=%b o=%b want 0",
               sample_out, sample_valid, overflow);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_passthrough();
    int t0;
    enable = 1'b1; dec_log2 = 3'd0;
    idle(2);
    clear_q();
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(1100, 100, 0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL pass_count got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== 1000 || exp_q[i] !== 1000)
        $display("FAIL pass_val[%0d] got %0d want 1000", i, obs_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (obs_cyc.size() == 0 || obs_cyc[0] - t0 !== 3)
      $display("FAIL pass_latency got %0d want 3",
               obs_cyc.size() ? obs_cyc[0] - t0 : -1);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_saturation();
    dec_log2 = 3'd0;
    pulse_clear();
    send(-32768, 1, 0);
    send(32767, -1, 0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== -32768 || obs_q[1] !== 32767)
      $display("FAIL sat_vals got n=%0d first=%0d want -32768,32767",
               obs_q.size(), obs_q.size() ? obs_q[0] : 0);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b1)
      $display("FAIL sat_ovf got %b want 1", overflow);
    else n_pass++;
    pulse_clear();
    idle(1);
    n_checks++;
    if (overflow !== 1'b0)
      $display("FAIL sat_clear got %b want 0", overflow);
    else n_pass++;
    send(-30000, 10000, 1);
    clear_overflow = 1'b1;
    idle(1);
    clear_overflow = 1'b0;
    idle(5);
    n_checks++;
    if (overflow !== 1'b1)
      $display("FAIL sat_set_wins got %b want 1", overflow);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_gaps();
    int v[8] = '{1, 2, 3, 6, 4, 4, 4, 4};
    dec_log2 = 3'd2;
    idle(2);
    for (int i = 0; i < 8; i++) send(v[i], 0, $urandom_range(0, 3));
    idle(6);
    n_checks++;
    if (obs_q.size() !== 2)
      $display("FAIL gap_count got %0d want 2", obs_q.size());
    else n_pass++;
    n_checks++;
    if (obs_q.size() < 2 || obs_q[0] !== 3 || obs_q[1] !== 4)
      $display("FAIL gap_vals got %0d,%0d want 3,4",
               obs_q.size() > 0 ? obs_q[0] : 0,
               obs_q.size() > 1 ? obs_q[1] : 0);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_floor();
    dec_log2 = 3'd1;
    idle(2);
    send(-1, 0, 0);
    send(-2, 0, 0);
    send(-32768, 0, 0);
    send(-32768, 0, 0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 2 || obs_q[0] !== -2 || obs_q[1] !== -32768)
      $display("FAIL floor_vals got n=%0d first=%0d want -2,-32768",
               obs_q.size(), obs_q.size() ? obs_q[0] : 0);
    else n_pass++;
    clear_q();
  endtask

  task automatic test_mode_change();
    dec_log2 = 3'd2;
    idle(2);
    send(100, 0, 0);
    send(100, 0, 0);
    idle(4);
    enable = 1'b0;
    model_flush();
    idle(4);
    enable = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) send(8, 0, 0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== 8)
      $display("FAIL disable_flush got n=%0d v=%0d want one 8",
               obs_q.size(), obs_q.size() ? obs_q[0] : 0);
    else n_pass++;
    clear_q();
    send(10, 0, 0);
    send(20, 0, 0);
    idle(4);
    dec_log2 = 3'd0;
    send(30, 0, 0);
    send(40, 0, 0);
    for (int i = 0; i < 3; i++) send(7 + i, 0, 0);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 4 || exp_q.size() !== 4)
      $display("FAIL dec_change_count got %0d want 4", obs_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL dec_change[%0d] got %0d want %0d", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    clear_q();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      dec_log2 = (r == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      idle(2);
      for (int i = 0; i < 72; i++)
        send($signed(16'($urandom)), $signed(16'($urandom_range(0, 3) == 0 ?
             $urandom : $urandom_range(0, 200))), $urandom_range(0, 2));
      idle(6);
      n_checks++;
      if (obs_q.size() !== exp_q.size())
        $display("FAIL rand%0d_count got %0d want %0d", r,
                 obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL rand%0d[%0d] got %0d want %0d", r, i,
                   obs_q[i], exp_q[i]);
        else n_pass++;
      end
      n_checks++;
      if (overflow !== m_ovf)
        $display("FAIL rand%0d_ovf got %b want %b", r, overflow, m_ovf);
      else n_pass++;
      enable = 1'b0;
      model_flush();
      idle(3);
      enable = 1'b1;
      pulse_clear();
      clear_q();
    end
  endtask

  task automatic test_reset_mid();
    dec_log2 = 3'd2;
    idle(2);
    send(-32768, 100, 0);
    send(5, 0, 0);
    idle(4);
    n_checks++;
    if (overflow !== 1'b1)
      $display("FAIL rst_pre_ovf got %b want 1", overflow);
    else n_pass++;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sample_out, sample_valid, overflow} !== 18'd0)
      $display("FAIL rst_async got out=%0d v=%b o=%b want 0",
               sample_out, sample_valid, overflow);
    else n_pass++;
    model_flush(); m_ovf = 0;
    idle(2);
    rst = 1'b0;
    idle(3);
    clear_q();
    for (int i = 0; i < 4; i++) send(5, 0, 1);
    idle(6);
    n_checks++;
    if (obs_q.size() !== 1 || obs_q[0] !== 5)
      $display("FAIL rst_restart got n=%0d v=%0d want one 5",
               obs_q.size(), obs_q.size() ? obs_q[0] : 0);
    else n_pass++;
    clear_q();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_gaps();
    test_floor();
    test_mode_change();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
